prng_scalar_sampler: RTL and testbench
======================================

Name: prng_scalar_sampler

Overview:
- Downstream consumer of the 256-bit PRNG output word (four parallel 64-bit generator lanes, advancing every clock).
- Turns the free-running random stream into a uniformly distributed scalar k in [1, n-1] by mask-and-reject sampling, for the elliptic-curve scalar multiplier.
- Hands k over on a valid/ready interface.
- Bounds the number of attempts and flags failure.

Parameters:
- WIDTH, 256, width of random word, modulus and scalar.
- MAX_TRIES, 16, maximum sampling attempts per request before failure.
- TRY_W, 5, width of attempt counter; must hold MAX_TRIES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rnd_in  input  WIDTH  current PRNG result word; may change every cycle.
- modulus  input  WIDTH  group order n; sampled on request acceptance.
- mask  input  WIDTH  AND-mask applied to rnd_in, normally 2^bitlen(n)-1; sampled with modulus.
- req  input  1  request one scalar; accepted only in IDLE.
- busy  output  1  high in every state except IDLE.
- k_out  output  WIDTH  accepted scalar; stable while k_valid=1.
- k_valid  output  1  scalar available.
- k_ready  input  1  consumer accepts k_out when k_valid and k_ready are both high.
- fail  output  1  one-cycle pulse when no scalar could be produced.

Behaviour:
- Reset: asynchronous on rst_n=0. State goes to IDLE. k_out=0, k_valid=0, fail=0, busy=0. Internal mod_q, mask_q, cand and tries are cleared. Reset mid-operation aborts the request silently, with no fail pulse.
- FSM states: IDLE, SAMPLE, CHECK, HOLD, FAIL.
- IDLE, req=1:
  - Latch mod_q=modulus and mask_q=mask. Set tries=0.
  - If modulus<=1, next state is FAIL.
  - Otherwise next state is SAMPLE.
- SAMPLE: register cand=rnd_in & mask_q; tries=tries+1; next state CHECK. One rnd_in word is consumed per attempt.
- CHECK (unsigned WIDTH-bit compare):
  - If cand!=0 and cand<mod_q: k_out=cand, next state HOLD.
  - Else if tries==MAX_TRIES: next state FAIL.
  - Else: next state SAMPLE.
- HOLD: k_valid=1, k_out held. On k_valid&k_ready, k_valid drops next cycle and the FSM returns to IDLE. A back-to-back req is accepted from IDLE no earlier than the following cycle.
- FAIL: fail=1 for exactly one cycle, k_valid=0, k_out unchanged, next state IDLE.
- Latency: with req accepted at edge 0, success on attempt t gives k_valid=1 after edge 2t+1, so the minimum is 3 edges. Failure by exhausted tries gives a fail pulse after edge 2*MAX_TRIES+1. Failure by modulus<=1 gives a fail pulse after edge 1.
- req is ignored while busy=1.
- modulus, mask and rnd_in changes have no effect except when sampled as stated.
- Boundary values:
  - cand=mod_q-1 is accepted.
  - cand=mod_q is rejected.
  - cand=0 is rejected.
  - mask_q=0 always rejects, so the request fails after MAX_TRIES.

Optional Feature:
- Macro SAMPLER_STATS_EN.
- Defined:
  - Adds output reject_cnt, 16 bits: total rejected candidates since reset, saturating at 0xFFFF.
  - Adds output fail_cnt, 8 bits: total fail pulses, saturating at 0xFF.
  - Both counters are cleared only by rst_n.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset and first request:
  - Stimulus: rst_n low 3 cycles, then release; modulus=0x11, mask=0x1F; rnd_in=0x05 constant; pulse req.
  - Response: all outputs 0 during reset; busy rises the cycle after req; k_valid=1 with k_out=0x05 after edge 3.
  - Stimulus: k_ready=1. Response: IDLE next cycle.
- Rejection sequence:
  - Stimulus: modulus=0x11, mask=0x1F; rnd_in per SAMPLE cycle = 0x00, 0x11, 0x3F(&mask=0x1F), 0x10.
  - Response: the first three are rejected; k_out=0x10 after 8 edges (attempt 4).
- Exhaustion:
  - Stimulus: MAX_TRIES=16, mask=0, modulus=0x11.
  - Response: fail pulse exactly one cycle after edge 33; k_valid never high.
  - With SAMPLER_STATS_EN: reject_cnt=16, fail_cnt=1.
- Degenerate modulus:
  - Stimulus: modulus=1, req.
  - Response: fail pulse after edge 1; no rnd_in consumed.
- Backpressure and ignored req:
  - Stimulus: success reached; k_ready=0 for 10 cycles while req pulses and rnd_in/modulus change.
  - Response: k_out and k_valid stable; no new request started.
  - Stimulus: k_ready=1. Response: handshake completes; IDLE.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously in CHECK.
  - Response: outputs 0 immediately; no fail pulse; after release a new req completes normally.

Source files
------------

// File: rtl/prng_scalar_sampler.sv
// Mask-and-reject sampler: turns the PRNG word stream into a uniform scalar k in [1, n-1].
// Define SAMPLER_STATS_EN to add the reject_cnt / fail_cnt statistics outputs.
module prng_scalar_sampler #(
    parameter int unsigned WIDTH     = 256,
    parameter int unsigned MAX_TRIES = 16,
    parameter int unsigned TRY_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rnd_in,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] mask,
    input  logic             req,
    output logic             busy,
    output logic [WIDTH-1:0] k_out,
    output logic             k_valid,
    input  logic             k_ready,
    output logic             fail
`ifdef SAMPLER_STATS_EN
    ,
    output logic [15:0]      reject_cnt,
    output logic [7:0]       fail_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        CHECK  = 3'd2,
        HOLD   = 3'd3,
        FAIL   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mod_q, mod_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [WIDTH-1:0]  k_out_q, k_out_d;
    logic              k_valid_q, k_valid_d;
    logic              fail_q, fail_d;
    logic              reject_evt;

    always_comb begin
        state_d    = state_q;
        mod_d      = mod_q;
        mask_d     = mask_q;
        cand_d     = cand_q;
        tries_d    = tries_q;
        k_out_d    = k_out_q;
        k_valid_d  = k_valid_q;
        fail_d     = 1'b0;
        reject_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    mod_d   = modulus;
                    mask_d  = mask;
                    tries_d = '0;
                    state_d = (modulus <= WIDTH'(1)) ? FAIL : SAMPLE;
                end
            end
            SAMPLE: begin
                cand_d  = rnd_in & mask_q;
                tries_d = tries_q + TRY_W'(1);
                state_d = CHECK;
            end
            CHECK: begin
                if ((cand_q != '0) && (cand_q < mod_q)) begin
                    k_out_d = cand_q;
                    state_d = HOLD;
                end else begin
                    reject_evt = 1'b1;
                    state_d    = (tries_q == TRY_W'(MAX_TRIES)) ? FAIL : SAMPLE;
                end
            end
            HOLD: begin
                // k_valid is registered, so it rises on the second HOLD cycle
                if (k_valid_q && k_ready) begin
                    k_valid_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    k_valid_d = 1'b1;
                end
            end
            FAIL: begin
                fail_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mod_q     <= '0;
            mask_q    <= '0;
            cand_q    <= '0;
            tries_q   <= '0;
            k_out_q   <= '0;
            k_valid_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mod_q     <= mod_d;
            mask_q    <= mask_d;
            cand_q    <= cand_d;
            tries_q   <= tries_d;
            k_out_q   <= k_out_d;
            k_valid_q <= k_valid_d;
            fail_q    <= fail_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign k_out   = k_out_q;
    assign k_valid = k_valid_q;
    assign fail    = fail_q;

`ifdef SAMPLER_STATS_EN
    logic [15:0] reject_cnt_q, reject_cnt_d;
    logic [7:0]  fail_cnt_q, fail_cnt_d;

    always_comb begin
        reject_cnt_d = reject_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        if (reject_evt && (reject_cnt_q != '1))
            reject_cnt_d = reject_cnt_q + 16'd1;
        if ((state_q == FAIL) && (fail_cnt_q != '1))
            fail_cnt_d = fail_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reject_cnt_q <= '0;
            fail_cnt_q   <= '0;
        end else begin
            reject_cnt_q <= reject_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign reject_cnt = reject_cnt_q;
    assign fail_cnt   = fail_cnt_q;
`endif

endmodule

// File: tb/tb_prng_scalar_sampler.sv
// Self-checking bench for prng_scalar_sampler: latency-rule model compared every cycle, plus directed literal checks.
module tb_prng_scalar_sampler;

    localparam int unsigned W = 256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] rnd_in = '0;
    logic [W-1:0] modulus = '0;
    logic [W-1:0] mask = '0;
    logic         req = 1'b0;
    logic         busy;
    logic [W-1:0] k_out;
    logic         k_valid;
    logic         k_ready = 1'b0;
    logic         fail;
`ifdef SAMPLER_STATS_EN
    logic [15:0]  reject_cnt;
    logic [7:0]   fail_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    prng_scalar_sampler #(.WIDTH(W), .MAX_TRIES(16), .TRY_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .rnd_in(rnd_in), .modulus(modulus), .mask(mask),
        .req(req), .busy(busy), .k_out(k_out), .k_valid(k_valid), .k_ready(k_ready),
        .fail(fail)
`ifdef SAMPLER_STATS_EN
        , .reject_cnt(reject_cnt), .fail_cnt(fail_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: event times derived from the latency rules relative to the accepting edge
    int           n, start, t, ev_kout, ev_valid, ev_fail;
    logic         m_busy, m_kvalid, m_fail, pend;
    logic [W-1:0] m_kout, m_mod, m_mask, m_k, c;
`ifdef SAMPLER_STATS_EN
    int           m_rej, m_fcnt;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; m_busy = 0; m_kvalid = 0; m_fail = 0; m_kout = '0; pend = 0;
            ev_kout = -1; ev_valid = -1; ev_fail = -1; start = 0;
`ifdef SAMPLER_STATS_EN
            m_rej = 0; m_fcnt = 0;
`endif
        end else begin
            n++;
            m_fail = 0;
            if (!m_busy) begin
                if (req) begin
                    m_busy = 1; start = n; m_mod = modulus; m_mask = mask;
                    ev_kout = -1; ev_valid = -1;
                    if (modulus <= 1) begin pend = 0; ev_fail = n + 1; end
                    else begin pend = 1; ev_fail = -1; end
                end
            end else begin
                if (pend && ((n - start) % 2 == 1)) begin
                    t = (n - start + 1) / 2;
                    c = rnd_in & m_mask;
                    if (c != 0 && c < m_mod) begin
                        pend = 0; m_k = c; ev_kout = n + 1; ev_valid = n + 2;
                    end else begin
`ifdef SAMPLER_STATS_EN
                        if (m_rej < 16'hFFFF) m_rej++;
`endif
                        if (t == 16) begin pend = 0; ev_fail = n + 2; end
                    end
                end
                if (n == ev_kout) m_kout = m_k;
                if (n == ev_valid) m_kvalid = 1;
                else if (m_kvalid && k_ready) begin m_kvalid = 0; m_busy = 0; end
                if (n == ev_fail) begin
                    m_fail = 1; m_busy = 0;
`ifdef SAMPLER_STATS_EN
                    if (m_fcnt < 8'hFF) m_fcnt++;
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", W'(busy), W'(m_busy));
        check("k_valid", W'(k_valid), W'(m_kvalid));
        check("k_out", k_out, m_kout);
        check("fail", W'(fail), W'(m_fail));
`ifdef SAMPLER_STATS_EN
        if (!m_busy) begin
            check("reject_cnt", W'(reject_cnt), W'(m_rej));
            check("fail_cnt", W'(fail_cnt), W'(m_fcnt));
        end
`endif
    end

    task automatic edges(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    logic [W-1:0] seq [4];
`ifdef SAMPLER_STATS_EN
    logic [15:0] rej0;
    logic [7:0]  fc0;
`endif

    initial begin
        #1 rst_n = 1'b0;
        edges(3);
        check("rst_busy", W'(busy), '0);
        check("rst_kvalid", W'(k_valid), '0);
        check("rst_kout", k_out, '0);
        check("rst_fail", W'(fail), '0);
        rst_n = 1'b1;
        edges(1);

        // First request: single attempt succeeds
        modulus = W'(8'h11); mask = W'(8'h1F); rnd_in = W'(8'h05);
        req = 1'b1;
        edges(1);
        check("s1_busy_rise", W'(busy), W'(1));
        req = 1'b0;
        edges(2);
        check("s1_kvalid_e2", W'(k_valid), '0);
        edges(1);
        check("s1_kvalid_e3", W'(k_valid), W'(1));
        check("s1_kout_e3", k_out, W'(8'h05));
        k_ready = 1'b1;
        edges(1);
        check("s1_idle", W'(busy), '0);
        check("s1_kvalid_drop", W'(k_valid), '0);
        k_ready = 1'b0;
        edges(1);

        // Rejections: 0 (zero), 0x11 (== n), 0x3F&0x1F (> n), then 0x10 (n-1) accepted
        seq[0] = W'(8'h00); seq[1] = W'(8'h11); seq[2] = W'(8'h3F); seq[3] = W'(8'h10);
        req = 1'b1;
        edges(1);
        req = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            rnd_in = seq[(j - 1) / 2];
            edges(1);
        end
        check("s2_kout_e8", k_out, W'(8'h10));
        check("s2_kvalid_e8", W'(k_valid), '0);
        edges(1);
        check("s2_kvalid_e9", W'(k_valid), W'(1));
        k_ready = 1'b1;
        edges(1);
        k_ready = 1'b0;
        edges(1);

        // Exhaustion with mask=0
`ifdef SAMPLER_STATS_EN
        rej0 = reject_cnt; fc0 = fail_cnt;
`endif
        modulus = W'(8'h11); mask = '0;
        req = 1'b1;
        edges(1);
        req = 1'b0;
        for (int j = 1; j <= 32; j++) begin
            rnd_in = {8{$urandom()}};
            edges(1);
        end
        check("s3_fail_e32", W'(fail), '0);
        check("s3_busy_e32", W'(busy), W'(1));
        edges(1);
        check("s3_fail_e33", W'(fail), W'(1));
        check("s3_busy_e33", W'(busy), '0);
        edges(1);
        check("s3_fail_e34", W'(fail), '0);
`ifdef SAMPLER_STATS_EN
        check("s3_reject_delta", W'(reject_cnt - rej0), W'(16));
        check("s3_failcnt_delta", W'(fail_cnt - fc0), W'(1));
`endif

        // Degenerate moduli 0 and 1
        for (int m = 0; m < 2; m++) begin
            modulus = W'(m); mask = W'(8'h1F);
            req = 1'b1;
            edges(1);
            req = 1'b0;
            check("s4_busy_e0", W'(busy), W'(1));
            check("s4_fail_e0", W'(fail), '0);
            edges(1);
            check("s4_fail_e1", W'(fail), W'(1));
            check("s4_busy_e1", W'(busy), '0);
            edges(1);
        end

        // Backpressure with req pulses and changing inputs
        modulus = W'(8'h11); mask = W'(8'h1F); rnd_in = W'(8'h07);
        req = 1'b1;
        edges(1);
        req = 1'b0;
        edges(3);
        for (int j = 0; j < 10; j++) begin
            check("s5_kvalid_hold", W'(k_valid), W'(1));
            check("s5_kout_hold", k_out, W'(8'h07));
            req = j[0];
            rnd_in = {8{$urandom()}};
            modulus = {8{$urandom()}};
            edges(1);
        end
        check("s5_kout_end", k_out, W'(8'h07));
        req = 1'b0; k_ready = 1'b1;
        modulus = W'(8'h11);
        edges(1);
        check("s5_idle", W'(busy), '0);
        check("s5_kvalid_drop", W'(k_valid), '0);
        k_ready = 1'b0;
        edges(1);

        // Asynchronous reset while in CHECK
        rnd_in = '0;
        req = 1'b1;
        edges(1);
        req = 1'b0;
        edges(1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_busy_rst", W'(busy), '0);
        check("s6_kvalid_rst", W'(k_valid), '0);
        check("s6_fail_rst", W'(fail), '0);
        check("s6_kout_rst", k_out, '0);
        edges(2);
        rst_n = 1'b1;
        edges(2);
        check("s6_no_fail", W'(fail), '0);
        rnd_in = W'(8'h03);
        req = 1'b1;
        edges(1);
        req = 1'b0;
        edges(3);
        check("s6_kvalid_after", W'(k_valid), W'(1));
        check("s6_kout_after", k_out, W'(8'h03));
        k_ready = 1'b1;
        edges(1);
        k_ready = 1'b0;
        edges(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
